ctrl_hazard_sb: RTL and testbench

Parametrised hazard scoreboard for the pipelined MIPS core. It replaces a fixed, purely combinational forward-select decoder with registered per-stage producer records. These records age the time-to-result (Tnew) every cycle, so the block covers any pipeline depth and any number of source operands. It sits beside the D-stage decoder, drives the pipeline-wide stall, reports which downstream stage holds the youngest producer of each D-stage source, and tracks multiply/divide unit (MDU) occupancy.

---
 rtl/ctrl_hazard_sb.sv | 136 +++++++++++++
 tb/tb_ctrl_hazard_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_hazard_sb.sv
// ctrl_hazard_sb: D-stage hazard scoreboard for the pipelined MIPS core.
// Per-stage producer records {v, a3, tnew} shift down the pipeline every
// cycle and age tnew toward zero. Each D-stage source is checked against
// them to pick the youngest forwarding stage and to detect data hazards.
// Optional feature macro: HAZ_MDU_EN builds the multiply/divide unit
// occupancy counter and the HI/LO hazard. Without it md_busy is tied low.
module ctrl_hazard_sb #(
  parameter int N_STAGE  = 3,
  parameter int N_SRC    = 2,
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = $clog2(N_STAGE + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC*REG_AW-1:0] src_a,
  input  logic [N_SRC*TW-1:0]     src_tuse,
  input  logic                    dst_we,
  input  logic [REG_AW-1:0]       dst_a3,
  input  logic [TW-1:0]           dst_tnew,
  input  logic                    md_start,
  input  logic                    md_is_div,
  input  logic                    md_use,
  output logic                    stall,
  output logic [N_SRC*SW-1:0]     fwd_stage,
  output logic                    md_busy
);

  // Producer records, index 1 = E stage, index N_STAGE = W stage.
  logic              v_r    [1:N_STAGE];
  logic [REG_AW-1:0] a3_r   [1:N_STAGE];
  logic [TW-1:0]     tnew_r [1:N_STAGE];

  logic [N_SRC-1:0]  data_haz_s;
  logic              md_haz_s;

  // One match/hazard slice per D-stage source operand.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] addr_s;
    logic [TW-1:0]     tuse_s;
    logic              used_s;
    logic              hit_s;
    logic [SW-1:0]     sel_s;
    logic [TW-1:0]     sel_tnew_s;

    assign addr_s = src_a[gi*REG_AW +: REG_AW];
    assign tuse_s = src_tuse[gi*TW +: TW];
    assign used_s = (tuse_s != {TW{1'b1}});

    // Scan oldest to youngest so the lowest-index match is the one kept.
    always_comb begin
      hit_s      = 1'b0;
      sel_s      = {SW{1'b0}};
      sel_tnew_s = {TW{1'b0}};
      for (int k = N_STAGE; k >= 1; k--) begin
        if (used_s && v_r[k] && (a3_r[k] != {REG_AW{1'b0}}) && (a3_r[k] == addr_s)) begin
          hit_s      = 1'b1;
          sel_s      = SW'(k);
          sel_tnew_s = tnew_r[k];
        end else begin
          hit_s      = hit_s;
        end
      end
    end

    assign fwd_stage[gi*SW +: SW] = sel_s;
    assign data_haz_s[gi]         = hit_s && (sel_tnew_s > tuse_s);
  end

  assign stall = (|data_haz_s) || md_haz_s;

  // Shift records down the pipe, aging tnew; E takes the D instruction or a bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= N_STAGE; k++) begin
        v_r[k]    <= 1'b0;
        a3_r[k]   <= {REG_AW{1'b0}};
        tnew_r[k] <= {TW{1'b0}};
      end
    end else begin
      if (stall) begin
        v_r[1]    <= 1'b0;
        a3_r[1]   <= {REG_AW{1'b0}};
        tnew_r[1] <= {TW{1'b0}};
      end else begin
        v_r[1]    <= dst_we && (dst_a3 != {REG_AW{1'b0}});
        a3_r[1]   <= dst_a3;
        tnew_r[1] <= dst_tnew;
      end
      for (int k = 2; k <= N_STAGE; k++) begin
        v_r[k]    <= v_r[k-1];
        a3_r[k]   <= a3_r[k-1];
        tnew_r[k] <= (tnew_r[k-1] == {TW{1'b0}}) ? {TW{1'b0}} : (tnew_r[k-1] - TW'(1));
      end
    end
  end

`ifdef HAZ_MDU_EN
  localparam int CW = $clog2(DIV_CYC + 1);

  logic          md_flag_r;
  logic          md_div_r;
  logic [CW-1:0] md_cnt_r;

  // Flag the cycle an MDU op sits in E, then load and run down the busy count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      md_flag_r <= 1'b0;
      md_div_r  <= 1'b0;
      md_cnt_r  <= {CW{1'b0}};
    end else begin
      md_flag_r <= md_start && !stall;
      md_div_r  <= md_is_div;
      if (md_flag_r) begin
        md_cnt_r <= md_div_r ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (md_cnt_r != {CW{1'b0}}) begin
        md_cnt_r <= md_cnt_r - CW'(1);
      end else begin
        md_cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign md_busy  = (md_cnt_r != {CW{1'b0}});
  assign md_haz_s = md_use && (md_busy || md_flag_r);
`else
  logic unused_md_s;

  assign unused_md_s = ^{md_start, md_is_div, md_use};
  assign md_busy     = 1'b0;
  assign md_haz_s    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_hazard_sb.sv
// Directed bench for ctrl_hazard_sb: a cycle-by-cycle vector table for the
// record pipeline, plus hand-written MDU sequences (HAZ_MDU_EN builds).
module tb_ctrl_hazard_sb;

  logic       clk;
  logic       reset_n;
  logic [9:0] src_a;
  logic [3:0] src_tuse;
  logic       dst_we;
  logic [4:0] dst_a3;
  logic [1:0] dst_tnew;
  logic       md_start;
  logic       md_is_div;
  logic       md_use;
  logic       stall;
  logic [3:0] fwd_stage;
  logic       md_busy;

  int n_vec;
  int n_err;

  ctrl_hazard_sb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_a     (src_a),
    .src_tuse  (src_tuse),
    .dst_we    (dst_we),
    .dst_a3    (dst_a3),
    .dst_tnew  (dst_tnew),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_use    (md_use),
    .stall     (stall),
    .fwd_stage (fwd_stage),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] u0;
    logic [1:0] u1;
    logic       we;
    logic [4:0] a3;
    logic [1:0] tn;
    logic       mds;
    logic       mdd;
    logic       mdu;
    logic       e_stall;
    logic [1:0] e_f0;
    logic [1:0] e_f1;
    logic       e_busy;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n   = v.rst_n;
    src_a     = {v.s1, v.s0};
    src_tuse  = {v.u1, v.u0};
    dst_we    = v.we;
    dst_a3    = v.a3;
    dst_tnew  = v.tn;
    md_start  = v.mds;
    md_is_div = v.mdd;
    md_use    = v.mdu;
  endtask

  task automatic idle_inputs();
    reset_n   = 1'b1;
    src_a     = 10'd0;
    src_tuse  = 4'b1111;
    dst_we    = 1'b0;
    dst_a3    = 5'd0;
    dst_tnew  = 2'd0;
    md_start  = 1'b0;
    md_is_div = 1'b0;
    md_use    = 1'b0;
  endtask

`ifdef HAZ_MDU_EN
  // Issue mult/div, then hold an mfhi in D and count stall and busy cycles.
  task automatic run_md(input logic is_div, input int exp_st, input int exp_busy, input string tag);
    int nst;
    int nbusy;
    nst   = 0;
    nbusy = 0;
    @(negedge clk);
    idle_inputs();
    md_start  = 1'b1;
    md_is_div = is_div;
    md_use    = 1'b1;
    #2;
    chk({tag, " issue stall"}, int'(stall), 0);
    @(negedge clk);
    md_start = 1'b0;
    #2;
    for (int c = 0; c < 40; c++) begin
      if (!stall) break;
      nst++;
      if (md_busy) nbusy++;
      @(negedge clk);
      #2;
    end
    chk({tag, " stall cycles"}, nst, exp_st);
    chk({tag, " busy cycles"}, nbusy, exp_busy);
    chk({tag, " busy after"}, int'(md_busy), 0);
    md_use = 1'b0;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    //            rst s0     s1     u0    u1    we    a3     tn    mds   mdd   mdu   st    f0    f1    busy
    tbl[0]  = '{1'b0, 5'd3, 5'd4, 2'd0, 2'd0, 1'b1, 5'd3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 5'd3, 5'd4, 2'd0, 2'd0, 1'b1, 5'd3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3, 5'd4, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    // load-use: lw $3 then add using $3
    tbl[4]  = '{1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 5'd3, 5'd9, 2'd1, 2'd1, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 5'd3, 5'd9, 2'd1, 2'd1, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    // ALU back-to-back: addu $5, then beq on $5
    tbl[7]  = '{1'b1, 5'd8, 5'd3, 2'd1, 2'd1, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    tbl[10] = '{1'b1, 5'd5, 5'd8, 2'd1, 2'd1, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 5'd6, 5'd6, 2'd1, 2'd3, 1'b1, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
    // youngest wins, $0 destinations never recorded
    tbl[12] = '{1'b1, 5'd7, 5'd7, 2'd0, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 5'd0, 5'd6, 2'd0, 2'd0, 1'b1, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0};
    tbl[14] = '{1'b1, 5'd7, 5'd7, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
    tbl[15] = '{1'b1, 5'd7, 5'd0, 2'd0, 2'd0, 1'b1, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 5'd7, 5'd7, 2'd0, 2'd0, 1'b1, 5'd9, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0};
    // tnew=3 producer aging through the pipe
    tbl[17] = '{1'b1, 5'd9, 5'd0, 2'd2, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 5'd9, 5'd0, 2'd2, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    tbl[19] = '{1'b1, 5'd9, 5'd9, 2'd0, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 1'b0};
    tbl[20] = '{1'b1, 5'd9, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[21] = '{1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};

    // Two reset edges so the records are defined before the first row.
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk($sformatf("row%0d stall", i), int'(stall), int'(tbl[i].e_stall));
      chk($sformatf("row%0d fwd0", i), int'(fwd_stage[1:0]), int'(tbl[i].e_f0));
      chk($sformatf("row%0d fwd1", i), int'(fwd_stage[3:2]), int'(tbl[i].e_f1));
      chk($sformatf("row%0d busy", i), int'(md_busy), int'(tbl[i].e_busy));
    end

`ifdef HAZ_MDU_EN
    run_md(1'b1, 11, 10, "div");
    run_md(1'b0, 6, 5, "mult");

    // Reset while the divide count sits at 4.
    begin
      int nbusy;
      nbusy = 0;
      @(negedge clk);
      idle_inputs();
      md_start  = 1'b1;
      md_is_div = 1'b1;
      md_use    = 1'b1;
      @(negedge clk);
      md_start = 1'b0;
      #2;
      for (int c = 0; c < 40; c++) begin
        if (md_busy) nbusy++;
        if (nbusy == 7) break;
        @(negedge clk);
        #2;
      end
      chk("rstdiv busy before", int'(md_busy), 1);
      chk("rstdiv stall before", int'(stall), 1);
      reset_n = 1'b0;
      @(negedge clk);
      #2;
      chk("rstdiv busy after", int'(md_busy), 0);
      chk("rstdiv stall after", int'(stall), 0);
      reset_n = 1'b1;
      md_use  = 1'b0;
    end
`else
    // MDU inputs must have no effect when the unit is not built.
    @(negedge clk);
    idle_inputs();
    md_start  = 1'b1;
    md_is_div = 1'b1;
    md_use    = 1'b1;
    #2;
    chk("nomdu issue stall", int'(stall), 0);
    @(negedge clk);
    md_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("nomdu stall c%0d", c), int'(stall), 0);
      chk($sformatf("nomdu busy c%0d", c), int'(md_busy), 0);
      @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
